// File: rtl/alu_pkg.sv
// Shared opcodes and FSM state encoding for the sequential ALU.
// Pure declarations: no latency or backpressure of its own.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_XOR = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_CLR = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } alu_state_t;

  function automatic logic is_mul(input logic [2:0] op);
    return op == OP_MUL;
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add unsigned multiplier: start loads operands, done pulses with the product valid.
// Latency WIDTH cycles after start; no backpressure, the parent must capture prod while done is high.
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH:0]     add_hi;
  logic [2*WIDTH-1:0] acc_step;

  // The multiplier lives in the low half of the accumulator and shifts out
  // as product bits shift in from the top.
  always_comb begin
    add_hi   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    acc_step = {add_hi, acc_q[WIDTH-1:1]};
  end

  assign prod = acc_step;
  assign done = (cnt_q == CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else if (start) begin
      mcand_q <= mcand;
      acc_q   <= {{WIDTH{1'b0}}, mplier};
      cnt_q   <= CNT_W'(WIDTH);
    end else if (cnt_q != '0) begin
      acc_q   <= acc_step;
      cnt_q   <= cnt_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready in and out; logic/add/sub results appear the edge they are accepted.
// Multiply takes WIDTH cycles when ALU_MUL_EN is defined; a held result stalls input until out_ready.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       sel,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic [WIDTH-1:0] res_hi,
  output logic             zf,
  output logic             cf,
  output logic             of
);

  alu_state_t       state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d;
  logic             zf_q, zf_d;
  logic             cf_q, cf_d;
  logic             of_q, of_d;
  logic             accept;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] diff;
  logic             lt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_cf;
  logic             alu_of;

`ifdef ALU_MUL_EN
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (mul_start),
    .mcand  (op1),
    .mplier (op2),
    .done   (mul_done),
    .prod   (mul_prod)
  );
`endif

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid && in_ready;

  always_comb begin
    sum     = {1'b0, op1} + {1'b0, op2};
    diff    = op1 - op2;
    lt      = (op1 < op2);
    alu_res = '0;
    alu_cf  = 1'b0;
    alu_of  = 1'b0;
    case (sel)
      OP_ADD: begin
        alu_res = sum[WIDTH-1:0];
        alu_cf  = sum[WIDTH];
      end
      OP_XOR: alu_res = op1 ^ op2;
      OP_SUB: begin
        alu_res = diff;
        alu_cf  = lt;
      end
      OP_OR:  alu_res = op1 | op2;
      OP_AND: alu_res = op1 & op2;
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, lt};
      // Only reaches the registers when the multiplier is compiled out.
      OP_MUL: alu_of  = 1'b1;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    res_d    = res_q;
    res_hi_d = res_hi_q;
    zf_d     = zf_q;
    cf_d     = cf_q;
    of_d     = of_q;
`ifdef ALU_MUL_EN
    mul_start = 1'b0;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
`ifdef ALU_MUL_EN
          if (is_mul(sel)) begin
            mul_start = 1'b1;
            state_d   = MUL;
          end else
`endif
          begin
            state_d  = DONE;
            res_d    = alu_res;
            res_hi_d = '0;
            zf_d     = (alu_res == '0);
            cf_d     = alu_cf;
            of_d     = alu_of;
          end
        end else if ((state_q == DONE) && out_ready) begin
          state_d = IDLE;
        end
      end
      MUL: begin
`ifdef ALU_MUL_EN
        if (mul_done) begin
          state_d  = DONE;
          res_d    = mul_prod[WIDTH-1:0];
          res_hi_d = mul_prod[2*WIDTH-1:WIDTH];
          zf_d     = (mul_prod[WIDTH-1:0] == '0);
          cf_d     = 1'b0;
          of_d     = (mul_prod[2*WIDTH-1:WIDTH] != '0);
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      res_q    <= '0;
      res_hi_q <= '0;
      zf_q     <= 1'b1;
      cf_q     <= 1'b0;
      of_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      res_q    <= res_d;
      res_hi_q <= res_hi_d;
      zf_q     <= zf_d;
      cf_q     <= cf_d;
      of_q     <= of_d;
    end
  end

  assign res    = res_q;
  assign res_hi = res_hi_q;
  assign zf     = zf_q;
  assign cf     = cf_q;
  assign of     = of_q;

endmodule
